// File: rtl/game_round_sequencer_if.sv
// Handshake bundle between the round sequencer and its environment.
// slave = sequencer side, master = game_top/board side driving key and strobes.
interface game_round_sequencer_if #(
  parameter int w_lives      = 2,
  parameter int score_digits = 4
);
  logic                      launch_key;
  logic                      round_won;
  logic                      round_lost;
  logic                      launch;
  logic                      freeze;
  logic [2:0]                state;
  logic [w_lives-1:0]        lives;
  logic [4*score_digits-1:0] score_bcd;

  modport slave (
    input  launch_key, round_won, round_lost,
    output launch, freeze, state, lives, score_bcd
  );

  modport master (
    output launch_key, round_won, round_lost,
    input  launch, freeze, state, lives, score_bcd
  );
endinterface

// File: rtl/game_round_sequencer.sv
// Round/session controller: launch pulses, freeze gating, lives, BCD score, result hold.
// Optional GAME_SEQ_AUTO_RELAUNCH_EN: HOLD timeout with lives left relaunches without a key.
module game_round_sequencer #(
  parameter int clk_mhz        = 50,
  parameter int start_lives    = 3,
  parameter int w_lives        = 2,
  parameter int result_hold_ms = 1000,
  parameter int score_digits   = 4
) (
  input logic                   clk,
  input logic                   rst,
  game_round_sequencer_if.slave bus
);

  localparam int tick_div = clk_mhz * 1000;
  localparam int w_tick   = $clog2(tick_div);
  localparam int w_ms     = $clog2(result_hold_ms + 1);
  localparam int w_score  = 4 * score_digits;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    PLAY   = 3'd2,
    HOLD   = 3'd3,
    OVER   = 3'd4
  } state_t;

  state_t               state_reg, state_next;
  logic                 key_q_reg;
  logic                 launch_reg, launch_next;
  logic                 freeze_reg, freeze_next;
  logic [w_lives-1:0]   lives_reg, lives_next;
  logic [w_score-1:0]   score_reg, score_next;
  logic [w_tick-1:0]    tick_reg, tick_next;
  logic [w_ms-1:0]      ms_reg, ms_next;

  logic                 key_rise;
  logic                 tick_wrap;
  logic                 hold_done;
  logic [score_digits:0] carry;
  logic [w_score-1:0]   score_inc;
  logic                 score_saturated;

  assign key_rise = bus.launch_key & ~key_q_reg;

  // Ripple BCD increment; a carry out of the top digit means every digit is 9.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < score_digits; gi++) begin : g_bcd
      logic [3:0] digit;
      assign digit = score_reg[4*gi +: 4];
      assign score_inc[4*gi +: 4] = carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) : digit;
      assign carry[gi+1] = carry[gi] & (digit == 4'd9);
    end
  endgenerate
  assign score_saturated = carry[score_digits];

  assign tick_wrap = (tick_reg == w_tick'(tick_div - 1));
  assign hold_done = tick_wrap && (ms_reg == w_ms'(result_hold_ms - 1));

  always_comb begin
    state_next = state_reg;
    lives_next = lives_reg;
    score_next = score_reg;
    tick_next  = '0;
    ms_next    = '0;
    case (state_reg)
      IDLE: begin
        if (key_rise) state_next = LAUNCH;
      end
      LAUNCH: begin
        state_next = PLAY;
      end
      PLAY: begin
        // A loss outranks a simultaneous win, which is then dropped.
        if (bus.round_lost) begin
          if (lives_reg != '0) lives_next = lives_reg - w_lives'(1);
          state_next = HOLD;
        end else if (bus.round_won) begin
          if (!score_saturated) score_next = score_inc;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (tick_wrap) begin
          ms_next = ms_reg + w_ms'(1);
        end else begin
          tick_next = tick_reg + w_tick'(1);
          ms_next   = ms_reg;
        end
        if (hold_done) begin
          if (lives_reg == '0) begin
            state_next = OVER;
          end else begin
`ifdef GAME_SEQ_AUTO_RELAUNCH_EN
            state_next = LAUNCH;
`else
            state_next = IDLE;
`endif
          end
        end
      end
      OVER: begin
        if (key_rise) begin
          lives_next = w_lives'(start_lives);
          score_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    launch_next = (state_next == LAUNCH);
    freeze_next = (state_next != PLAY);
  end

  // Counters stay cleared outside HOLD, so every HOLD entry starts a fresh interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      key_q_reg  <= 1'b1;
      launch_reg <= 1'b0;
      freeze_reg <= 1'b1;
      lives_reg  <= w_lives'(start_lives);
      score_reg  <= '0;
      tick_reg   <= '0;
      ms_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      key_q_reg  <= bus.launch_key;
      launch_reg <= launch_next;
      freeze_reg <= freeze_next;
      lives_reg  <= lives_next;
      score_reg  <= score_next;
      tick_reg   <= tick_next;
      ms_reg     <= ms_next;
    end
  end

  assign bus.launch    = launch_reg;
  assign bus.freeze    = freeze_reg;
  assign bus.state     = state_reg;
  assign bus.lives     = lives_reg;
  assign bus.score_bcd = score_reg;

endmodule
